// File: rtl/riscv_muldiv_unit_if.sv
// Handshake bundle between the execute stage and the mul/div unit.
// Latency: n/a (wires only). Backpressure: in_ready/out_ready carried here.
// The master drives operands and consumes results; the slave is the unit itself.
interface riscv_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Flag;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, Result, Flag
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, Result, Flag
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle on magnitudes.
// Latency: out_valid first high WIDTH+1 edges after accept, for every op.
// Backpressure: single op in flight; result held in DONE until out_ready.
module riscv_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] p_hi, p_lo;
    logic [WIDTH-1:0] result_q;
    logic             flag_q;
    logic             in_ready_c, out_valid_c;

    // Operand capture: signedness decoded from the incoming op
    logic             in_sa, in_sb;
    logic [WIDTH-1:0] in_a_mag, in_b_mag;

    assign in_sa    = (bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11)) & bus.A[WIDTH-1];
    assign in_sb    = (bus.op[2] ? ~bus.op[0] : ~bus.op[1]) & bus.B[WIDTH-1];
    assign in_a_mag = in_sa ? -bus.A : bus.A;
    assign in_b_mag = in_sb ? -bus.B : bus.B;

    // One shift-add step: low half holds the remaining multiplier bits
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});

    // One restoring step: p_hi is the partial remainder, p_lo shifts dividend out / quotient in
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, b_mag};
    assign div_diff  = div_shift[WIDTH-1:0] - b_mag;

    // Sign correction and output selection for FIX
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s, a_orig, fix_res;
    logic               neg, b_zero;

    assign b_zero = (b_mag == '0);
    assign neg    = sign_a ^ sign_b;
    assign prod   = {p_hi, p_lo};
    assign prod_s = neg ? -prod : prod;
    assign quot_s = neg ? -p_lo : p_lo;
    assign rem_s  = sign_a ? -p_hi : p_hi;
    assign a_orig = sign_a ? -a_mag : a_mag;

    // Signed overflow (most-negative / -1) falls out naturally: |q| = 2^(W-1), both signs set
    always_comb begin
        fix_res = '0;
        if (op_q[2]) begin
            if (b_zero) fix_res = op_q[1] ? a_orig : '1;
            else        fix_res = op_q[1] ? rem_s  : quot_s;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = CALC;
            end
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q   <= bus.op;
                    sign_a <= in_sa;
                    sign_b <= in_sb;
                    a_mag  <= in_a_mag;
                    b_mag  <= in_b_mag;
                    cnt    <= CW'(WIDTH);
                    p_hi   <= '0;
                    p_lo   <= bus.op[2] ? in_a_mag : in_b_mag;
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op_q[2]) begin
                        p_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], div_ok};
                    end else begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    flag_q   <= op_q[2] & b_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.Result    = result_q;
    assign bus.Flag      = flag_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_riscv_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    riscv_muldiv_unit_if #(.WIDTH(32)) b32();
    riscv_muldiv_unit_if #(.WIDTH(8))  b8();

    riscv_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    riscv_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    // Issues one op at negedge, scrambles operands after the accept edge,
    // waits for out_valid (bounded), then completes the handshake.
    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic f, output int lat);
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = o; b32.A = a; b32.B = b;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0; b32.op = ~o; b32.A = ~a; b32.B = ~b;
        lat = 999;
        for (int k = 0; k < 80; k++) begin
            if (b32.out_valid) begin lat = k; break; end
            @(posedge clk); @(negedge clk);
        end
        r = b32.Result; f = b32.Flag;
        b32.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        b32.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic f, output int lat);
        @(negedge clk);
        b8.in_valid = 1'b1; b8.op = o; b8.A = a; b8.B = b;
        @(posedge clk);
        @(negedge clk);
        b8.in_valid = 1'b0; b8.A = ~a; b8.B = ~b;
        lat = 999;
        for (int k = 0; k < 40; k++) begin
            if (b8.out_valid) begin lat = k; break; end
            @(posedge clk); @(negedge clk);
        end
        r = b8.Result; f = b8.Flag;
        b8.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        b32.in_valid = 1'b0; b32.op = '0; b32.A = '0; b32.B = '0; b32.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.op  = '0; b8.A  = '0; b8.B  = '0; b8.out_ready  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (b32.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", b32.in_ready); else passes++;
        checks++; if (b32.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", b32.out_valid); else passes++;
        checks++; if (b32.Result !== 32'h0) $display("FAIL reset_result got %h want 0", b32.Result); else passes++;
        checks++; if (b32.Flag !== 1'b0) $display("FAIL reset_flag got %b want 0", b32.Flag); else passes++;
        checks++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) $display("FAIL reset_w8_hs got rdy=%b vld=%b want 1/0", b8.in_ready, b8.out_valid); else passes++;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic f; int lat;
        run32(3'b000, 32'd7, 32'hFFFF_FFFD, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFEB) $display("FAIL mul_result got %h want ffffffeb", r); else passes++;
        checks++; if (f !== 1'b0) $display("FAIL mul_flag got %b want 0", f); else passes++;
        checks++; if (lat !== 33) $display("FAIL mul_latency got %0d want 33", lat); else passes++;
        run32(3'b001, 32'h8000_0000, 32'h8000_0000, r, f, lat);
        checks++; if (r !== 32'h4000_0000) $display("FAIL mulh_result got %h want 40000000", r); else passes++;
        run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu_result got %h want fffffffe", r); else passes++;
        run32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu_result got %h want ffffffff", r); else passes++;
        checks++; if (lat !== 33) $display("FAIL mulhsu_latency got %0d want 33", lat); else passes++;
    endtask

    task automatic test_div();
        logic [31:0] r; logic f; int lat;
        run32(3'b100, 32'hFFFF_FFF9, 32'd2, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_result got %h want fffffffd", r); else passes++;
        checks++; if (lat !== 33) $display("FAIL div_latency got %0d want 33", lat); else passes++;
        run32(3'b110, 32'hFFFF_FFF9, 32'd2, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_result got %h want ffffffff", r); else passes++;
        run32(3'b101, 32'd100, 32'd7, r, f, lat);
        checks++; if (r !== 32'd14) $display("FAIL divu_result got %h want e", r); else passes++;
        run32(3'b111, 32'd100, 32'd7, r, f, lat);
        checks++; if (r !== 32'd2) $display("FAIL remu_result got %h want 2", r); else passes++;
    endtask

    task automatic test_div_zero();
        logic [31:0] r; logic f; int lat;
        run32(3'b101, 32'd5, 32'd0, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFFF || f !== 1'b1) $display("FAIL divu_zero got %h/%b want ffffffff/1", r, f); else passes++;
        checks++; if (lat !== 33) $display("FAIL divu_zero_latency got %0d want 33", lat); else passes++;
        run32(3'b111, 32'd5, 32'd0, r, f, lat);
        checks++; if (r !== 32'd5 || f !== 1'b1) $display("FAIL remu_zero got %h/%b want 5/1", r, f); else passes++;
        run32(3'b100, 32'hFFFF_FFF9, 32'd0, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFFF || f !== 1'b1) $display("FAIL div_zero_neg got %h/%b want ffffffff/1", r, f); else passes++;
        run32(3'b110, 32'hFFFF_FFF9, 32'd0, r, f, lat);
        checks++; if (r !== 32'hFFFF_FFF9 || f !== 1'b1) $display("FAIL rem_zero_neg got %h/%b want fffffff9/1", r, f); else passes++;
        run32(3'b000, 32'd3, 32'd0, r, f, lat);
        checks++; if (r !== 32'd0 || f !== 1'b0) $display("FAIL mul_by_zero got %h/%b want 0/0", r, f); else passes++;
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic f; int lat;
        run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, f, lat);
        checks++; if (r !== 32'h8000_0000 || f !== 1'b0) $display("FAIL div_ovf got %h/%b want 80000000/0", r, f); else passes++;
        checks++; if (lat !== 33) $display("FAIL div_ovf_latency got %0d want 33", lat); else passes++;
        run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, f, lat);
        checks++; if (r !== 32'h0 || f !== 1'b0) $display("FAIL rem_ovf got %h/%b want 0/0", r, f); else passes++;
    endtask

    task automatic test_backpressure();
        int bad;
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = 3'b000; b32.A = 32'd7; b32.B = 32'hFFFF_FFFD;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        for (int k = 0; k < 80 && !b32.out_valid; k++) begin
            @(posedge clk); @(negedge clk);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (b32.out_valid !== 1'b1 || b32.Result !== 32'hFFFF_FFEB || b32.Flag !== 1'b0 || b32.in_ready !== 1'b0)
                bad++;
            b32.in_valid = i[0]; b32.op = 3'b101; b32.A = 32'd9; b32.B = 32'd0;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else passes++;
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        b32.out_ready = 1'b0;
        checks++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) $display("FAIL bp_release got vld=%b rdy=%b want 0/1", b32.out_valid, b32.in_ready); else passes++;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.out_valid !== 1'b0) bad++;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (bad !== 0) $display("FAIL bp_no_extra_op got %0d valid cycles want 0", bad); else passes++;
        checks++; if (b32.Result !== 32'hFFFF_FFEB) $display("FAIL bp_idle_hold got %h want ffffffeb", b32.Result); else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic f; int lat;
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = 3'b101; b32.A = 32'h1234_5678; b32.B = 32'd3;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) $display("FAIL midrst_hs got vld=%b rdy=%b want 0/1", b32.out_valid, b32.in_ready); else passes++;
        checks++; if (b32.Result !== 32'h0) $display("FAIL midrst_result got %h want 0", b32.Result); else passes++;
        run32(3'b101, 32'd100, 32'd7, r, f, lat);
        checks++; if (r !== 32'd14 || f !== 1'b0) $display("FAIL midrst_divu got %h/%b want e/0", r, f); else passes++;
        checks++; if (lat !== 33) $display("FAIL midrst_latency got %0d want 33", lat); else passes++;
    endtask

    task automatic test_width8();
        logic [7:0] r; logic f; int lat;
        run8(3'b100, 8'h80, 8'hFF, r, f, lat);
        checks++; if (r !== 8'h80 || f !== 1'b0) $display("FAIL w8_div_ovf got %h/%b want 80/0", r, f); else passes++;
        checks++; if (lat !== 9) $display("FAIL w8_latency got %0d want 9", lat); else passes++;
        run8(3'b011, 8'hFF, 8'hFF, r, f, lat);
        checks++; if (r !== 8'hFE) $display("FAIL w8_mulhu got %h want fe", r); else passes++;
        run8(3'b000, 8'd7, 8'hFD, r, f, lat);
        checks++; if (r !== 8'hEB) $display("FAIL w8_mul got %h want eb", r); else passes++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_width8();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
